// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/forwarding unit and its MDU tracker.
// Holds forwarding-select encoding, tracker state encoding and default latencies.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks an in-flight MULT/DIV: busy for exactly MUL_LAT/DIV_LAT cycles after issue.
// Ports: clk, reset (async high), start_i, is_div_i -> busy_o, err_o (sticky restart-while-busy).
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CW      = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic err_o
);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
                end
            end
            MD_BUSY: begin
                // A second issue is flagged but never restarts the count.
                if (start_i) err_d = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy_o = (state_q == MD_BUSY);
    assign err_o  = err_q;

endmodule

// File: rtl/hazard_unit_mdu.sv
// Hazard/forwarding unit for the 5-stage pipeline with MULT/DIV busy tracking.
// Outputs forwarding selects, StallF/StallD/FlushE, MdBusy/MdErr and stall-cause counters.
// Counters are live only when HAZARD_PERF_EN is defined; otherwise they read 0.
module hazard_unit_mdu
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        MemtoRegE,
    input  logic [1:0]        MemtoRegM,
    input  logic              BranchD,
    input  logic              bneD,
    input  logic              jrD,
    input  logic              MdStartE,
    input  logic              MdIsDivE,
    input  logic              MdUseD,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdErr,
    output logic [PERF_W-1:0] LdStallCnt,
    output logic [PERF_W-1:0] BrStallCnt,
    output logic [PERF_W-1:0] MdStallCnt
);

    fwd_sel_t fwd_a, fwd_b;
    logic     lwstall, brstall, jrstall, mdstall, stall;
    logic     e_hit_s, e_hit_t, m_hit_s, m_hit_t;

    always_comb begin
        fwd_a = FWD_RF;
        if (rsE != '0 && rsE == WriteRegM && RegWriteM)      fwd_a = FWD_MEM;
        else if (rsE != '0 && rsE == WriteRegW && RegWriteW) fwd_a = FWD_WB;
        fwd_b = FWD_RF;
        if (rtE != '0 && rtE == WriteRegM && RegWriteM)      fwd_b = FWD_MEM;
        else if (rtE != '0 && rtE == WriteRegW && RegWriteW) fwd_b = FWD_WB;
    end

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;
    assign ForwardAD = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;

    // Producers a D-stage compare cannot forward from yet: ALU result in E, load in M.
    assign e_hit_s = RegWriteE && WriteRegE != '0 && WriteRegE == rsD;
    assign e_hit_t = RegWriteE && WriteRegE != '0 && WriteRegE == rtD;
    assign m_hit_s = (MemtoRegM != 2'b00) && WriteRegM != '0 && WriteRegM == rsD;
    assign m_hit_t = (MemtoRegM != 2'b00) && WriteRegM != '0 && WriteRegM == rtD;

    assign lwstall = (MemtoRegE != 2'b00) && rtE != '0 && (rsD == rtE || rtD == rtE);
    assign brstall = (BranchD | bneD) & (e_hit_s | e_hit_t | m_hit_s | m_hit_t);
    assign jrstall = jrD & (e_hit_s | m_hit_s);
    // MdStartE counts as busy so a dependent op right behind the issuer waits too.
    assign mdstall = MdUseD & (MdBusy | MdStartE);

    assign stall  = lwstall | brstall | jrstall | mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    mdu_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_trk (
        .clk      (clk),
        .reset    (reset),
        .start_i  (MdStartE),
        .is_div_i (MdIsDivE),
        .busy_o   (MdBusy),
        .err_o    (MdErr)
    );

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] ld_cnt_q, br_cnt_q, md_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt_q <= '0;
            br_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            if (lwstall && ~&ld_cnt_q) ld_cnt_q <= ld_cnt_q + PERF_W'(1);
            if ((brstall || jrstall) && ~&br_cnt_q) br_cnt_q <= br_cnt_q + PERF_W'(1);
            if (mdstall && ~&md_cnt_q) md_cnt_q <= md_cnt_q + PERF_W'(1);
        end
    end

    assign LdStallCnt = ld_cnt_q;
    assign BrStallCnt = br_cnt_q;
    assign MdStallCnt = md_cnt_q;
`else
    assign LdStallCnt = '0;
    assign BrStallCnt = '0;
    assign MdStallCnt = '0;
`endif

endmodule
